audio_sample_fifo: RTL and testbench
====================================

Name: audio_sample_fifo

Overview:
- Downstream consumer of the audio interface's parallel outputs, codec_left[31:0] and codec_right[31:0].
- Detects each audio frame boundary from the ADC LR clock. Captures one stereo sample pair per frame into a FIFO.
- Exposes the FIFO, status and control through an Avalon-MM slave so the HPS can drain microphone data without missing frames.
- Sits in soc_system between audio_interface and the lightweight HPS-to-FPGA bridge.

Parameters:
- DEPTH, 64, FIFO entries (stereo pairs); must be a power of 2, at least 4.
- AW, 6, log2(DEPTH).
- SYNC_STAGES, 2, flip-flop stages for the aud_adclrck synchronizer.

Ports:
- clk_clk  in  1  system clock (50 MHz)
- reset_reset_n  in  1  asynchronous, active-low reset
- codec_left  in  32  left sample from audio_interface
- codec_right  in  32  right sample from audio_interface
- aud_adclrck  in  1  ADC LR clock, asynchronous to clk_clk
- avs_address  in  2  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered
- irq  out  1  level interrupt, registered

Behaviour:
- Reset: all pointers, count, sticky bits, control, avs_readdata and irq go to 0. Reset is asynchronous and active-low; one clock, clk_clk.
- Frame detect:
  - aud_adclrck passes through SYNC_STAGES flops, then one more delay flop.
  - frame_edge = falling edge of the synchronized signal; it is a single-cycle pulse.
- Capture: on the cycle after frame_edge, sample {codec_left, codec_right}. audio_interface updates these only on the opposite LRCK phase, so they are stable here.
- Push: a push occurs when CONTROL.enable=1 at capture.
  - If the FIFO is full, the pair is dropped and STATUS.overflow sets.
  - Pointers wrap modulo DEPTH.
- Register map:
  - 0 LEFT (RO): returns the left word of the head entry. Does not pop.
  - 1 RIGHT (RO): returns the right word of the head entry and pops it.
  - 2 STATUS:
    - [AW:0] fill count (0..DEPTH)
    - [16] empty
    - [17] full
    - [24] overflow sticky
    - [25] underflow sticky
    - Writing 1 to bit 24 or 25 clears that bit; other bits are read-only.
  - 3 CONTROL (RW):
    - [0] enable
    - [1] irq_en
    - [2] flush, self-clearing and always reads 0
    - [23:16] threshold
    - All other bits read 0.
- Read timing: fixed latency of 1. avs_readdata is valid on the cycle after avs_read and holds its value until the next read.
- Read from an empty FIFO: reading RIGHT returns 0, does no pop and sets underflow. Reading LEFT returns 0, does no pop and does not set underflow.
- Simultaneous push and pop: both happen and the count is unchanged. When the FIFO is full, a same-cycle pop frees the slot, so the push succeeds with no overflow.
- Flush:
  - Zeroes pointers and count on the write cycle; sticky bits are unaffected.
  - Flush beats a same-cycle push or pop.
  - A capture landing on the flush cycle is discarded.
- Clearing enable: stops new pushes; the FIFO contents remain readable.
- Simultaneous read and write: legal. The read returns pre-write state.
- irq: registered value of irq_en & (threshold != 0) & (count >= threshold). It deasserts the cycle after the count drops below threshold.
- Storage: DEPTH x 64-bit array. Head read is combinational from the array into the avs_readdata register.
- No combinational path from avs_* to irq.

Test Plan:
- Reset, then read STATUS -> 0x00010000 (empty=1, count 0); irq=0; avs_readdata=0.
- enable=1; drive 3 LRCK frames with left=0x11110000+n, right=0x22220000+n. Then read LEFT, RIGHT three times -> values n=0,1,2 in order. STATUS count goes 3→0, empty=1.
- enable=1; drive 66 frames with no reads (DEPTH=64) -> count=64, full=1, overflow=1. First RIGHT read returns frame 0's right; frames 64 and 65 are lost. Write 0x01000000 to STATUS -> overflow=0.
- Reads on an empty FIFO:
  - Read RIGHT while empty -> readdata=0, underflow=1, count stays 0.
  - Read LEFT while empty -> underflow unchanged.
- threshold=4, irq_en=1; push 4 frames -> irq=1 after the 4th capture. One RIGHT read -> irq=0 one cycle after the pop.
- Fill to 10 entries, then write CONTROL flush with a frame_edge capture on the same cycle -> count=0, empty=1, overflow unchanged. The next frame is captured normally (count=1).

Source files
------------

// File: rtl/audio_sample_fifo.sv
// Stereo audio sample FIFO: captures one {left, right} pair per ADC LR clock
// frame and exposes the queue, status and control through an Avalon-MM slave.
module audio_sample_fifo #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned AW          = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] codec_left,
  input  logic [31:0] codec_right,
  input  logic        aud_adclrck,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lrck_dly_q;
  logic                   capture_q;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          enable_q, enable_d;
  logic          irq_en_q, irq_en_d;
  logic [7:0]    threshold_q, threshold_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          irq_q, irq_d;

  logic        frame_edge;
  logic        empty, full;
  logic        pop_req, pop, push_req, push, flush;
  logic        status_wr, control_wr;
  logic [63:0] head;
  logic [31:0] status_word, control_word;
  logic        unused_wdata;

  assign frame_edge = lrck_dly_q & ~sync_q[SYNC_STAGES-1];

  assign empty      = (count_q == '0);
  assign full       = (count_q == FullCount);
  assign head       = mem[rd_ptr_q];
  assign status_wr  = avs_write && (avs_address == 2'd2);
  assign control_wr = avs_write && (avs_address == 2'd3);
  assign flush      = control_wr && avs_writedata[2];
  assign pop_req    = avs_read && (avs_address == 2'd1);
  assign push_req   = capture_q && enable_q;
  // Flush wins over both queue operations; a pop frees the slot for a push when full.
  assign pop        = pop_req && !empty && !flush;
  assign push       = push_req && !flush && (!full || pop);

  assign status_word  = {6'd0, underflow_q, overflow_q, 6'd0, full, empty,
                         {(15 - AW){1'b0}}, count_q};
  assign control_word = {8'd0, threshold_q, 14'd0, irq_en_q, enable_q};

  assign unused_wdata = ^{avs_writedata[31:26], avs_writedata[15:3]};

  // LR clock synchronizer, edge-detect delay flop and capture strobe
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q     <= '0;
      lrck_dly_q <= 1'b0;
      capture_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], aud_adclrck};
      lrck_dly_q <= sync_q[SYNC_STAGES-1];
      capture_q  <= frame_edge;
    end
  end

  // Sample storage; no reset needed since reads of empty slots are masked
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {codec_left, codec_right};
    end
  end

  // Next-state for pointers, count, sticky bits, control, read data and irq
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    threshold_d = threshold_q;
    readdata_d  = readdata_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end

    if (status_wr) begin
      if (avs_writedata[24]) overflow_d  = 1'b0;
      if (avs_writedata[25]) underflow_d = 1'b0;
    end
    // Setting a sticky bit takes priority over a same-cycle clear
    if (push_req && !flush && full && !pop) overflow_d = 1'b1;
    if (pop_req && empty)                   underflow_d = 1'b1;

    if (control_wr) begin
      enable_d    = avs_writedata[0];
      irq_en_d    = avs_writedata[1];
      threshold_d = avs_writedata[23:16];
    end

    // Reads see pre-write state
    if (avs_read) begin
      unique case (avs_address)
        2'd0:    readdata_d = empty ? 32'd0 : head[63:32];
        2'd1:    readdata_d = empty ? 32'd0 : head[31:0];
        2'd2:    readdata_d = status_word;
        default: readdata_d = control_word;
      endcase
    end

    irq_d = irq_en_q && (threshold_q != 8'd0) && (32'(count_q) >= 32'(threshold_q));
  end

  // State registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      threshold_q <= 8'd0;
      readdata_q  <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      threshold_q <= threshold_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed, table-driven bench for audio_sample_fifo.
module tb_audio_sample_fifo;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [31:0] codec_left = '0;
  logic [31:0] codec_right = '0;
  logic        aud_adclrck = 1'b1;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  audio_sample_fifo #(
    .DEPTH(64),
    .AW(6),
    .SYNC_STAGES(2)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .codec_left(codec_left),
    .codec_right(codec_right),
    .aud_adclrck(aud_adclrck),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .irq(irq)
  );

  always #10 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All bus/frame tasks start and end on a falling clock edge
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_read    = 1'b1;
    avs_address = a;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_write     = 1'b1;
    avs_address   = a;
    avs_writedata = d;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  // Lowers LRCK and returns on the cycle whose rising edge performs the capture
  task automatic frame_lower(input int n);
    codec_left  = 32'h1111_0000 + 32'(n);
    codec_right = 32'h2222_0000 + 32'(n);
    aud_adclrck = 1'b0;
    repeat (3) @(negedge clk_clk);
  endtask

  task automatic frame_finish();
    repeat (3) @(negedge clk_clk);
    aud_adclrck = 1'b1;
    repeat (4) @(negedge clk_clk);
  endtask

  task automatic frame(input int n);
    frame_lower(n);
    frame_finish();
  endtask

  task automatic add_rd(input logic [1:0] a, input logic [31:0] e);
    vec_t v;
    v.is_wr = 1'b0; v.addr = a; v.data = '0; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic add_wr(input logic [1:0] a, input logic [31:0] d);
    vec_t v;
    v.is_wr = 1'b1; v.addr = a; v.data = d; v.exp = '0;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    logic [31:0] r;
    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        bus_write(tbl[i].addr, tbl[i].data);
      end else begin
        bus_read(tbl[i].addr, r);
        check($sformatf("%s[%0d]", tag, i), r, tbl[i].exp);
      end
    end
    tbl.delete();
  endtask

  initial begin
    logic [31:0] r;

    // Reset
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    check("reset_readdata", avs_readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    bus_read(2'd2, r);
    check("reset_status", r, 32'h0001_0000);

    // Three frames, then drain in order
    bus_write(2'd3, 32'h1);
    for (int n = 0; n < 3; n++) frame(n);
    add_rd(2'd2, 32'h0000_0003);
    add_rd(2'd0, 32'h1111_0000);
    add_rd(2'd1, 32'h2222_0000);
    add_rd(2'd2, 32'h0000_0002);
    add_rd(2'd0, 32'h1111_0001);
    add_rd(2'd1, 32'h2222_0001);
    add_rd(2'd0, 32'h1111_0002);
    add_rd(2'd1, 32'h2222_0002);
    add_rd(2'd2, 32'h0001_0000);
    run_table("basic");

    // Overflow: 66 frames into 64 slots
    for (int n = 0; n < 66; n++) frame(n);
    add_rd(2'd2, 32'h0102_0040);
    add_rd(2'd0, 32'h1111_0000);
    add_wr(2'd2, 32'h0100_0000);
    add_rd(2'd2, 32'h0002_0040);
    run_table("ovf");

    // Pop on the capture cycle while full: push must succeed without overflow
    frame_lower(100);
    bus_read(2'd1, r);
    frame_finish();
    check("full_pop_push_data", r, 32'h2222_0000);
    bus_read(2'd2, r);
    check("full_pop_push_status", r, 32'h0002_0040);
    for (int i = 0; i < 62; i++) bus_read(2'd1, r);
    add_rd(2'd0, 32'h1111_003F);
    add_rd(2'd1, 32'h2222_003F);
    add_rd(2'd0, 32'h1111_0064);
    add_rd(2'd1, 32'h2222_0064);
    add_rd(2'd2, 32'h0001_0000);
    // Empty reads: RIGHT sets underflow, LEFT does not
    add_rd(2'd1, 32'h0);
    add_rd(2'd2, 32'h0201_0000);
    add_wr(2'd2, 32'h0200_0000);
    add_rd(2'd0, 32'h0);
    add_rd(2'd2, 32'h0001_0000);
    run_table("drain");

    // Threshold interrupt
    bus_write(2'd3, 32'h0004_0003);
    bus_read(2'd3, r);
    check("control_rb", r, 32'h0004_0003);
    for (int n = 200; n < 203; n++) frame(n);
    check("irq_below_thr", {31'd0, irq}, 32'h0);
    frame(203);
    check("irq_at_thr", {31'd0, irq}, 32'h1);
    bus_read(2'd1, r);
    check("irq_pop_data", r, 32'h2222_00C8);
    check("irq_pop_same_cycle", {31'd0, irq}, 32'h1);
    @(negedge clk_clk);
    check("irq_after_pop", {31'd0, irq}, 32'h0);
    bus_write(2'd3, 32'h0004_0007);
    bus_read(2'd3, r);
    check("flush_reads_zero", r, 32'h0004_0003);
    bus_read(2'd2, r);
    check("flush_status", r, 32'h0001_0000);

    // Flush racing a capture; sticky underflow must survive
    bus_write(2'd3, 32'h1);
    bus_read(2'd1, r);
    for (int n = 0; n < 10; n++) frame(300 + n);
    bus_read(2'd2, r);
    check("fill10_status", r, 32'h0200_000A);
    frame_lower(310);
    bus_write(2'd3, 32'h5);
    frame_finish();
    bus_read(2'd2, r);
    check("flush_capture_status", r, 32'h0201_0000);
    frame(311);
    bus_read(2'd2, r);
    check("post_flush_status", r, 32'h0200_0001);
    bus_read(2'd0, r);
    check("post_flush_left", r, 32'h1111_0137);
    bus_write(2'd3, 32'h1);
    repeat (2) @(negedge clk_clk);
    check("readdata_hold", avs_readdata, 32'h1111_0137);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
